// File: rtl/contactor_driver.sv
// Per-position contactor drive and supervision: gates the close request with
// the interlock permit, sequences the coil through CLOSING/OPENING with
// timeouts, and debounces the auxiliary contact that is fed back to the ring.
module contactor_driver #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CLOSE_TMO  = 1000,
  parameter int unsigned OPEN_TMO   = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd,
  input  logic       i_permit,
  input  logic       i_aux_fb,
  input  logic       i_fault_clr,
  output logic       o_coil,
  output logic       o_closed,
  output logic       o_fault,
  output logic [1:0] o_fault_code,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_OPEN    = 3'b000,
    ST_CLOSING = 3'b001,
    ST_CLOSED  = 3'b010,
    ST_OPENING = 3'b011,
    ST_FAULT   = 3'b100
  } state_e;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_CLOSE_TMO = 2'b01;
  localparam logic [1:0] FC_OPEN_TMO  = 2'b10;
  localparam logic [1:0] FC_FB_CHANGE = 2'b11;

  // Terminal counts: the compare fires on the last cycle allowed in a state.
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TMO - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TMO - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             closed_q, closed_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             coil_q, coil_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             go_c;

  assign go_c = i_cmd & i_permit;

  // Two-flop synchroniser for the asynchronous auxiliary contact.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_aux_fb;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip on the DEB_CYCLES-th.
  always_comb begin
    deb_cnt_d = '0;
    closed_d  = closed_q;
    if (sync2_q != closed_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        closed_d = ~closed_q;
      end else begin
        deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt_q <= '0;
      closed_q  <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      closed_q  <= closed_d;
    end
  end

  // Next-state and fault-code decode; branch order encodes event priority.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_OPEN: begin
        if (closed_q) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_FB_CHANGE;
        end else if (go_c) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        if (!go_c) begin
          state_d = ST_OPENING;
        end else if (closed_q) begin
          state_d = ST_CLOSED;
        end else if (timer_q == CLOSE_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_CLOSE_TMO;
        end
      end
      ST_CLOSED: begin
        if (!go_c) begin
          state_d = ST_OPENING;
        end else if (!closed_q) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_FB_CHANGE;
        end
      end
      ST_OPENING: begin
        // Close requests are deliberately ignored until the contact is seen open.
        if (!closed_q) begin
          state_d = ST_OPEN;
        end else if (timer_q == OPEN_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_OPEN_TMO;
        end
      end
      ST_FAULT: begin
        if (i_fault_clr && !i_cmd && !closed_q) begin
          state_d      = ST_OPEN;
          fault_code_d = FC_NONE;
        end
      end
      default: begin
        state_d      = ST_OPEN;
        fault_code_d = FC_NONE;
      end
    endcase
  end

  // State timer restarts on every transition and saturates otherwise.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (!(&timer_q)) begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they register with the state.
  always_comb begin
    coil_d  = (state_d == ST_CLOSING) || (state_d == ST_CLOSED);
    fault_d = (state_d == ST_FAULT);
  end

  // Sequencer registers; async reset drops the coil without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_OPEN;
      timer_q      <= '0;
      coil_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      coil_q       <= coil_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign o_coil       = coil_q;
  assign o_closed     = closed_q;
  assign o_fault      = fault_q;
  assign o_fault_code = fault_code_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_contactor_driver.sv
// Scoreboard bench for contactor_driver: stimulus pushes expected output
// vectors tagged with the cycle they must appear; a negedge monitor pops them.
module tb_contactor_driver;

  localparam logic [2:0] S_OPEN    = 3'b000;
  localparam logic [2:0] S_CLOSING = 3'b001;
  localparam logic [2:0] S_CLOSED  = 3'b010;
  localparam logic [2:0] S_OPENING = 3'b011;
  localparam logic [2:0] S_FAULT   = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd, permit, aux, clr;
  logic       o_coil, o_closed, o_fault;
  logic [1:0] o_fault_code;
  logic [2:0] o_state;
  logic [7:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] want;
  } exp_t;

  exp_t sb[$];

  contactor_driver #(
    .DEB_CYCLES(4),
    .CLOSE_TMO (20),
    .OPEN_TMO  (20),
    .CNT_W     (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd       (cmd),
    .i_permit    (permit),
    .i_aux_fb    (aux),
    .i_fault_clr (clr),
    .o_coil      (o_coil),
    .o_closed    (o_closed),
    .o_fault     (o_fault),
    .o_fault_code(o_fault_code),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {o_fault, o_fault_code, o_state, o_coil, o_closed};

  // Vector layout: {fault, code[1:0], state[2:0], coil, closed}.
  function automatic logic [7:0] pk(input logic f, input logic [1:0] c,
                                    input logic [2:0] s, input logic coil,
                                    input logic cl);
    return {f, c, s, coil, cl};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %b expected %b (fault,code,state,coil,closed)",
               tag, cyc, act, want);
    end
  endtask

  task automatic expect_at(input int k, input string tag, input logic [7:0] want);
    exp_t e;
    e.cyc  = cyc + k;
    e.tag  = tag;
    e.want = want;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Close with feedback following immediately; CLOSED is reached 7 edges later.
  task automatic do_close(input string tag);
    cmd = 1'b1; permit = 1'b1; aux = 1'b1;
    expect_at(7, tag, pk(0, 2'b00, S_CLOSED, 1, 1));
    tick(8);
  endtask

  // Compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check_eq((e.cyc == cyc) ? e.tag : {e.tag, "_late"}, obs, e.want);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", sb.size());
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd = 1'b0; permit = 1'b0; aux = 1'b0; clr = 1'b0;
    tick(3);
    expect_at(0, "reset", pk(0, 2'b00, S_OPEN, 0, 0));
    rst_n = 1'b1;
    tick(2);

    // Normal close/open.
    cmd = 1'b1; permit = 1'b1;
    expect_at(0, "pre_close", pk(0, 2'b00, S_OPEN, 0, 0));
    expect_at(1, "close_coil", pk(0, 2'b00, S_CLOSING, 1, 0));
    tick(5);
    aux = 1'b1;
    expect_at(5, "fb_not_yet", pk(0, 2'b00, S_CLOSING, 1, 0));
    expect_at(6, "fb_closed", pk(0, 2'b00, S_CLOSING, 1, 1));
    expect_at(7, "closed_state", pk(0, 2'b00, S_CLOSED, 1, 1));
    tick(8);
    cmd = 1'b0;
    expect_at(1, "open_coil", pk(0, 2'b00, S_OPENING, 0, 1));
    tick(1);
    aux = 1'b0;
    expect_at(5, "open_fb_hold", pk(0, 2'b00, S_OPENING, 0, 1));
    expect_at(6, "open_fb", pk(0, 2'b00, S_OPENING, 0, 0));
    expect_at(7, "open_state", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(8);

    // Close timeout.
    cmd = 1'b1; permit = 1'b1;
    expect_at(1, "tmo_closing", pk(0, 2'b00, S_CLOSING, 1, 0));
    expect_at(20, "tmo_edge", pk(0, 2'b00, S_CLOSING, 1, 0));
    expect_at(21, "tmo_fault", pk(1, 2'b01, S_FAULT, 0, 0));
    tick(21);
    clr = 1'b1;
    expect_at(1, "clr_blocked_cmd", pk(1, 2'b01, S_FAULT, 0, 0));
    tick(1);
    cmd = 1'b0;
    expect_at(1, "clr_exit", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(1);
    clr = 1'b0;
    tick(2);

    // Weld: feedback stays closed while opening.
    do_close("weld_closed");
    cmd = 1'b0;
    expect_at(1, "weld_opening", pk(0, 2'b00, S_OPENING, 0, 1));
    expect_at(20, "weld_edge", pk(0, 2'b00, S_OPENING, 0, 1));
    expect_at(21, "weld_fault", pk(1, 2'b10, S_FAULT, 0, 1));
    tick(21);
    clr = 1'b1;
    expect_at(1, "weld_clr_hold1", pk(1, 2'b10, S_FAULT, 0, 1));
    expect_at(3, "weld_clr_hold3", pk(1, 2'b10, S_FAULT, 0, 1));
    tick(3);
    aux = 1'b0;
    expect_at(6, "weld_fb_drop", pk(1, 2'b10, S_FAULT, 0, 0));
    expect_at(7, "weld_exit", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(8);
    clr = 1'b0;

    // One-cycle permit loss opens; no re-close until OPEN is reached.
    do_close("pl_closed");
    permit = 1'b0;
    expect_at(1, "pl_opening", pk(0, 2'b00, S_OPENING, 0, 1));
    tick(1);
    permit = 1'b1;
    aux = 1'b0;
    expect_at(1, "pl_no_reclose", pk(0, 2'b00, S_OPENING, 0, 1));
    expect_at(6, "pl_fb_drop", pk(0, 2'b00, S_OPENING, 0, 0));
    expect_at(7, "pl_open", pk(0, 2'b00, S_OPEN, 0, 0));
    expect_at(8, "pl_reclose", pk(0, 2'b00, S_CLOSING, 1, 0));
    tick(8);
    cmd = 1'b0;
    expect_at(1, "pl_release", pk(0, 2'b00, S_OPENING, 0, 0));
    expect_at(2, "pl_release_open", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(3);

    // 3-cycle bounce while open: feedback must not change.
    for (int k = 1; k <= 10; k++) expect_at(k, "bounce_open", pk(0, 2'b00, S_OPEN, 0, 0));
    aux = 1'b1;
    tick(3);
    aux = 1'b0;
    tick(8);

    // 3-cycle dropout while closed, then a real unexpected drop.
    do_close("bd_closed");
    for (int k = 1; k <= 10; k++) expect_at(k, "bounce_closed", pk(0, 2'b00, S_CLOSED, 1, 1));
    aux = 1'b0;
    tick(3);
    aux = 1'b1;
    tick(8);
    aux = 1'b0;
    expect_at(6, "drop_fb", pk(0, 2'b00, S_CLOSED, 1, 0));
    expect_at(7, "drop_fault", pk(1, 2'b11, S_FAULT, 0, 0));
    tick(8);
    cmd = 1'b0; clr = 1'b1;
    expect_at(1, "drop_clr", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(1);
    clr = 1'b0;
    tick(2);

    // Feedback arrival at the timeout cycle wins.
    cmd = 1'b1; permit = 1'b1; aux = 1'b0;
    tick(14);
    aux = 1'b1;
    expect_at(6, "prio_fb_t19", pk(0, 2'b00, S_CLOSING, 1, 1));
    expect_at(7, "prio_closed", pk(0, 2'b00, S_CLOSED, 1, 1));
    tick(7);
    cmd = 1'b0; aux = 1'b0;
    expect_at(1, "prio_opening", pk(0, 2'b00, S_OPENING, 0, 1));
    expect_at(7, "prio_open", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(8);

    // Permit loss on that same edge wins over both.
    cmd = 1'b1; permit = 1'b1; aux = 1'b0;
    tick(14);
    aux = 1'b1;
    tick(6);
    permit = 1'b0;
    expect_at(0, "prio2_fb_t19", pk(0, 2'b00, S_CLOSING, 1, 1));
    expect_at(1, "prio2_opening", pk(0, 2'b00, S_OPENING, 0, 1));
    tick(1);
    cmd = 1'b0; permit = 1'b1; aux = 1'b0;
    expect_at(7, "prio2_open", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(8);

    // Asynchronous reset mid-CLOSED.
    do_close("ar_closed");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", obs, pk(0, 2'b00, S_OPEN, 0, 0));
    tick(1);
    expect_at(0, "rst_held", pk(0, 2'b00, S_OPEN, 0, 0));
    #2;
    rst_n = 1'b1;
    expect_at(1, "rst_release", pk(0, 2'b00, S_CLOSING, 1, 0));
    tick(1);
    cmd = 1'b0; aux = 1'b0;
    expect_at(1, "ar_opening", pk(0, 2'b00, S_OPENING, 0, 0));
    expect_at(2, "ar_open", pk(0, 2'b00, S_OPEN, 0, 0));
    tick(4);

    check_eq("sb_drain", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
